// File: rtl/obstacle_ctrl_pkg.sv
// Shared types and slot-bus register map for the obstacle motion controller.
// Exports: state_t, REG_* offsets, REG_SEL_BIT, reg_addr().
package obstacle_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        STEP,
        WR_CTRL,
        WR_X
    } state_t;

    localparam logic [1:0] REG_BYPASS = 2'b00;
    localparam logic [1:0] REG_X0     = 2'b01;
    localparam logic [1:0] REG_Y0     = 2'b10;
    localparam logic [1:0] REG_CTRL   = 2'b11;

    localparam int REG_SEL_BIT = 13;

    // Sprite-core register address: select bit set, offset in [1:0].
    function automatic logic [13:0] reg_addr(input logic [1:0] off);
        logic [13:0] a;
        a = '0;
        a[REG_SEL_BIT] = 1'b1;
        a[1:0] = off;
        return a;
    endfunction

endpackage

// File: rtl/obstacle_motion_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing only when step=1.
// Ports: clk, reset (async, active-low), step, state[15:0].
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] state
);

    logic fb;

    assign fb = state[15] ^ state[13] ^ state[12] ^ state[10];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[14:0], fb};
        end
    end

endmodule

// File: rtl/obstacle_motion_ctrl.sv
// Per-frame obstacle motion sequencer sharing the sprite slot bus with the CPU.
// Ports: clk, reset, x/y frame counter, run, speed, cpu_* in; slot_*, busy, overrun, obs_x out.
module obstacle_motion_ctrl
    import obstacle_ctrl_pkg::*;
#(
    parameter int              NOBS         = 3,
    parameter int              INIT_X       = 640,
    parameter int              SPACING      = 224,
    parameter int              RESPAWN_BASE = 640,
    parameter int              GROUND_Y     = 400,
    parameter logic [15:0]     LFSR_SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [10:0]         x,
    input  logic [10:0]         y,
    input  logic                run,
    input  logic [3:0]          speed,
    input  logic [NOBS-1:0]     cpu_cs,
    input  logic                cpu_write,
    input  logic [13:0]         cpu_addr,
    input  logic [31:0]         cpu_wr_data,
    output logic [NOBS-1:0]     slot_cs,
    output logic                slot_write,
    output logic [13:0]         slot_addr,
    output logic [31:0]         slot_wr_data,
    output logic                busy,
    output logic                overrun,
    output logic [11*NOBS-1:0]  obs_x
);

    localparam int IW = (NOBS > 1) ? $clog2(NOBS) : 1;

    state_t         state, state_n;
    logic [IW-1:0]  idx, idx_n;
    logic [1:0]     phase, phase_n;
    logic [10:0]    pos [NOBS];
    logic [10:0]    cur_pos, pos_val;
    logic [1:0]     variant;
    logic           init_done, init_fin;
    logic           prev_org, frame_start;
    logic           cpu_grant, last, respawn;
    logic           ctl_wr, pos_ld, lfsr_step;
    logic [1:0]     ctl_off;
    logic [31:0]    ctl_data;
    logic [15:0]    lfsr;
    logic           unused_lfsr;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:10];
    assign cpu_grant   = cpu_write && (|cpu_cs);
    assign cur_pos     = pos[idx];
    assign last        = (idx == IW'(NOBS - 1));
    assign respawn     = cur_pos < {7'b0, speed};

    // One pulse on entry to (0,0), however long each pixel lasts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_org    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            prev_org    <= (x == '0) && (y == '0);
            frame_start <= (x == '0) && (y == '0) && !prev_org;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            idx       <= '0;
            phase     <= '0;
            variant   <= '0;
            init_done <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < NOBS; i++)
                pos[i] <= 11'(INIT_X + i * SPACING);
        end else begin
            state <= state_n;
            idx   <= idx_n;
            phase <= phase_n;
            if (pos_ld)
                pos[idx] <= pos_val;
            // Capture the variant before the LFSR steps past it.
            if (lfsr_step)
                variant <= lfsr[9:8];
            if (init_fin)
                init_done <= 1'b1;
            if (frame_start && state != IDLE)
                overrun <= 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        phase_n   = phase;
        ctl_wr    = 1'b0;
        ctl_off   = REG_BYPASS;
        ctl_data  = '0;
        pos_ld    = 1'b0;
        pos_val   = cur_pos;
        lfsr_step = 1'b0;
        init_fin  = 1'b0;
        unique case (state)
            INIT: begin
                ctl_wr = 1'b1;
                unique case (phase)
                    2'd0: begin
                        ctl_off  = REG_BYPASS;
                        ctl_data = '0;
                    end
                    2'd1: begin
                        ctl_off  = REG_Y0;
                        ctl_data = 32'(GROUND_Y);
                    end
                    default: begin
                        ctl_off  = REG_X0;
                        ctl_data = {21'b0, cur_pos};
                    end
                endcase
                if (!cpu_grant) begin
                    if (phase == 2'd2) begin
                        phase_n = '0;
                        if (last) begin
                            idx_n    = '0;
                            init_fin = 1'b1;
                            state_n  = IDLE;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end else begin
                        phase_n = phase + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (frame_start && run && init_done) begin
                    idx_n   = '0;
                    state_n = STEP;
                end
            end
            STEP: begin
                pos_ld = 1'b1;
                if (respawn) begin
                    pos_val   = 11'(RESPAWN_BASE) + {3'b0, lfsr[7:0]};
                    lfsr_step = 1'b1;
                    state_n   = WR_CTRL;
                end else begin
                    pos_val = cur_pos - {7'b0, speed};
                    state_n = WR_X;
                end
            end
            WR_CTRL: begin
                ctl_wr   = 1'b1;
                ctl_off  = REG_CTRL;
                ctl_data = {27'b0, 3'b001, variant};
                if (!cpu_grant)
                    state_n = WR_X;
            end
            WR_X: begin
                ctl_wr   = 1'b1;
                ctl_off  = REG_X0;
                ctl_data = {21'b0, cur_pos};
                if (!cpu_grant) begin
                    if (last) begin
                        state_n = IDLE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = STEP;
                    end
                end
            end
            default: state_n = INIT;
        endcase
    end

    // CPU wins the bus; everything is forced low while reset is held.
    always_comb begin
        slot_cs      = '0;
        slot_write   = 1'b0;
        slot_addr    = '0;
        slot_wr_data = '0;
        if (reset) begin
            if (cpu_grant) begin
                slot_cs      = cpu_cs;
                slot_write   = 1'b1;
                slot_addr    = cpu_addr;
                slot_wr_data = cpu_wr_data;
            end else if (ctl_wr) begin
                slot_cs      = NOBS'(1) << idx;
                slot_write   = 1'b1;
                slot_addr    = reg_addr(ctl_off);
                slot_wr_data = ctl_data;
            end
        end
    end

    assign busy = reset && (state != IDLE);

    always_comb begin
        obs_x = '0;
        for (int i = 0; i < NOBS; i++)
            obs_x[11*i +: 11] = reset ? pos[i] : 11'd0;
    end

endmodule

// File: tb/tb_obstacle_motion_ctrl.sv
// Directed bench for obstacle_motion_ctrl with a write-order scoreboard.
// An independent model predicts every controller slot write.
module tb_obstacle_motion_ctrl;

    localparam int NOBS = 3;

    typedef struct packed {
        logic [2:0]  cs;
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic        run;
    logic [3:0]  speed;
    logic [2:0]  cpu_cs;
    logic        cpu_write;
    logic [13:0] cpu_addr;
    logic [31:0] cpu_wr_data;
    logic [2:0]  slot_cs;
    logic        slot_write;
    logic [13:0] slot_addr;
    logic [31:0] slot_wr_data;
    logic        busy, overrun;
    logic [32:0] obs_x;

    wr_t         exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mpos[NOBS];
    logic [15:0] mlfsr;

    obstacle_motion_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .run          (run),
        .speed        (speed),
        .cpu_cs       (cpu_cs),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wr_data  (cpu_wr_data),
        .slot_cs      (slot_cs),
        .slot_write   (slot_write),
        .slot_addr    (slot_addr),
        .slot_wr_data (slot_wr_data),
        .busy         (busy),
        .overrun      (overrun),
        .obs_x        (obs_x)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic wr_t mk(input int i, input logic [1:0] off,
                               input int d);
        wr_t w;
        w.cs   = 3'(1 << i);
        w.addr = 14'h2000 | {12'b0, off};
        w.data = d;
        return w;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_init();
        mlfsr = 16'hACE1;
        for (int i = 0; i < NOBS; i++) begin
            mpos[i] = 640 + 224 * i;
            exp_q.push_back(mk(i, 2'b00, 0));
            exp_q.push_back(mk(i, 2'b10, 400));
            exp_q.push_back(mk(i, 2'b01, mpos[i]));
        end
    endtask

    task automatic model_frame(input int s);
        for (int i = 0; i < NOBS; i++) begin
            if (mpos[i] < s) begin
                exp_q.push_back(mk(i, 2'b11, 32'h4 | int'(mlfsr[9:8])));
                mpos[i] = 640 + int'(mlfsr[7:0]);
                mlfsr = lfsr_next(mlfsr);
            end else begin
                mpos[i] = mpos[i] - s;
            end
            exp_q.push_back(mk(i, 2'b01, mpos[i]));
        end
    endtask

    // Every controller write is popped and compared in order.
    always @(negedge clk) begin
        if (reset && slot_write && !(cpu_write && |cpu_cs)) begin
            check("queue_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("slot_write", {slot_cs, slot_addr, slot_wr_data},
                      exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input int s, input logic r);
        speed = 4'(s);
        run   = r;
        if (r)
            model_frame(s);
        x = 0;
        y = 0;
        tick();
        x = 1;
        y = 1;
        repeat (15) tick();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic init_seq();
        for (int k = 0; k < 3 * NOBS; k++) begin
            @(negedge clk);
            check("init_write", slot_write, 1);
            check("init_busy", busy, 1);
        end
        @(negedge clk);
        check("init_busy_fall", busy, 0);
        check("init_idle_write", slot_write, 0);
        #1;
        check("init_drain", exp_q.size(), 0);
        check("init_obs_x", obs_x, {11'd1088, 11'd864, 11'd640});
        tick();
    endtask

    initial begin
        reset = 1'b0;
        x = 5;
        y = 5;
        run = 0;
        speed = 0;
        cpu_cs = 0;
        cpu_write = 0;
        cpu_addr = 0;
        cpu_wr_data = 0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_write", slot_write, 0);
        check("rst_cs", slot_cs, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_obs_x", obs_x, 0);

        model_init();
        @(posedge clk);
        #1 reset = 1'b1;
        init_seq();

        // First moving frame, with exact latency from the pulse.
        speed = 4;
        run = 1;
        model_frame(4);
        x = 0;
        y = 0;
        tick();
        x = 1;
        y = 1;
        @(negedge clk);
        check("pulse_busy", busy, 0);
        @(negedge clk);
        check("step_busy", busy, 1);
        check("step_nowrite", slot_write, 0);
        @(negedge clk);
        check("wr_x0_write", slot_write, 1);
        check("wr_x0_data", slot_wr_data, 636);
        repeat (12) tick();
        check("f1_drain", exp_q.size(), 0);
        check("f1_obs_x", obs_x, {11'd1084, 11'd860, 11'd636});

        do_frame(4, 0);
        check("run0_obs_x", obs_x, {11'd1084, 11'd860, 11'd636});
        do_frame(0, 1);
        check("spd0_obs_x", obs_x, {11'd1084, 11'd860, 11'd636});

        // Walk obstacle 0 down to 3, then respawn it with speed 4.
        repeat (42) do_frame(15, 1);
        do_frame(3, 1);
        check("pos_at_3", obs_x[10:0], 3);
        do_frame(4, 1);
        check("respawn_x", obs_x[10:0], 865);

        // CPU holds the bus across obstacle 0's x0 write.
        speed = 4;
        model_frame(4);
        x = 0;
        y = 0;
        tick();
        x = 1;
        y = 1;
        tick();
        cpu_write = 1;
        cpu_cs = 3'b010;
        cpu_addr = 14'h2001;
        cpu_wr_data = 32'h123;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("cpu_cs", slot_cs, 3'b010);
            check("cpu_data", {slot_write, slot_addr, slot_wr_data},
                  {1'b1, 14'h2001, 32'h123});
            tick();
        end
        cpu_write = 0;
        cpu_cs = 0;
        @(negedge clk);
        check("held_x0_cs", slot_cs, 3'b001);
        check("held_x0_data", slot_wr_data, 861);
        repeat (14) tick();
        check("cpu_drain", exp_q.size(), 0);

        // A second frame start while busy only raises overrun.
        check("ovr_before", overrun, 0);
        model_frame(4);
        x = 0;
        y = 0;
        tick();
        x = 1;
        y = 1;
        tick();
        x = 0;
        y = 0;
        tick();
        x = 1;
        y = 1;
        repeat (14) tick();
        check("ovr_drain", exp_q.size(), 0);
        check("ovr_set", overrun, 1);
        do_frame(4, 1);
        check("ovr_sticky", overrun, 1);

        // Reset lands in WR_CTRL of obstacle 0.
        for (int k = 0; k < 100 && mpos[0] >= 15; k++)
            do_frame(15, 1);
        speed = 15;
        model_frame(15);
        x = 0;
        y = 0;
        tick();
        x = 1;
        y = 1;
        repeat (2) tick();
        @(negedge clk);
        check("ctrl_addr", {slot_write, slot_cs, slot_addr},
              {1'b1, 3'b001, 14'h2003});
        #1 reset = 1'b0;
        #1;
        check("mid_rst_slot", {slot_cs, slot_write, slot_addr, slot_wr_data}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovr", overrun, 0);
        exp_q.delete();
        model_init();
        repeat (2) tick();
        @(posedge clk);
        #1 reset = 1'b1;
        init_seq();

        for (int k = 0; k < 100 && mpos[0] >= 15; k++)
            do_frame(15, 1);
        do_frame(15, 1);
        check("reseed_respawn_x", obs_x[10:0], 865);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
